// File: rtl/pzbcm_wrr_arbiter.sv
// rtl/pzbcm_wrr_arbiter.sv - weighted round-robin arbiter with registered, held grants and a free handshake
// Optional: define PZBCM_WRR_ARBITER_WEIGHT_ZERO_SKIP_EN to mask zero-weight requesters out of arbitration.
module pzbcm_wrr_arbiter #(
  parameter int REQUESTS      = 4,
  parameter int WEIGHT_WIDTH  = 8,
  parameter bit ONEHOT_GRANT  = 1,
  localparam int GRANT_WIDTH  = ONEHOT_GRANT ? REQUESTS : ((REQUESTS > 1) ? $clog2(REQUESTS) : 1)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clear,
  input  logic [REQUESTS*WEIGHT_WIDTH-1:0] i_weight,
  input  logic [REQUESTS-1:0]              i_request,
  input  logic                             i_free,
  output logic                             o_grant_valid,
  output logic [GRANT_WIDTH-1:0]           o_grant
);
  localparam int IDX_W = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(REQUESTS - 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        grantee, grantee_next;
  logic [IDX_W-1:0]        pointer, pointer_next;
  logic [WEIGHT_WIDTH-1:0] credit, credit_next;
  logic [WEIGHT_WIDTH-1:0] weights [REQUESTS];
  logic [REQUESTS-1:0]     candidates;
  logic [IDX_W-1:0]        search_idx;
  logic [IDX_W-1:0]        winner;
  logic                    found;
  logic [WEIGHT_WIDTH-1:0] load_credit;

  always_comb begin
    for (int i = 0; i < REQUESTS; i++) begin
      weights[i] = i_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

`ifdef PZBCM_WRR_ARBITER_WEIGHT_ZERO_SKIP_EN
  always_comb begin
    for (int i = 0; i < REQUESTS; i++) begin
      candidates[i] = i_request[i] && (weights[i] != '0);
    end
  end
`else
  assign candidates = i_request;
`endif

  // Cyclic search starting just after the last new grantee, so it ends up lowest priority.
  always_comb begin
    found      = 1'b0;
    winner     = pointer;
    search_idx = pointer;
    for (int off = 1; off <= REQUESTS; off++) begin
      search_idx = IDX_W'((int'(pointer) + off) % REQUESTS);
      if (!found && candidates[search_idx]) begin
        found  = 1'b1;
        winner = search_idx;
      end
    end
  end

  // Weight 0 loads the same credit as weight 1: one transaction per turn.
  assign load_credit = (weights[winner] == '0) ? '0 : weights[winner] - WEIGHT_WIDTH'(1);

  always_comb begin
    state_next   = state;
    grantee_next = grantee;
    pointer_next = pointer;
    credit_next  = credit;
    if (i_clear) begin
      state_next   = IDLE;
      pointer_next = PTR_RESET;
      credit_next  = '0;
    end else if (state == IDLE) begin
      if (found) begin
        state_next   = GRANTED;
        grantee_next = winner;
        pointer_next = winner;
        credit_next  = load_credit;
      end
    end else if (i_free && (credit != '0) && i_request[grantee]) begin
      credit_next = credit - WEIGHT_WIDTH'(1);
    end else if (i_free || !i_request[grantee]) begin
      // A withdrawn request acts as a free that also forfeits the remaining credit.
      if (found) begin
        grantee_next = winner;
        pointer_next = winner;
        credit_next  = load_credit;
      end else begin
        state_next  = IDLE;
        credit_next = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      grantee <= '0;
      pointer <= PTR_RESET;
      credit  <= '0;
    end else begin
      state   <= state_next;
      grantee <= grantee_next;
      pointer <= pointer_next;
      credit  <= credit_next;
    end
  end

  assign o_grant_valid = (state == GRANTED);

  generate
    if (ONEHOT_GRANT) begin : g_onehot
      assign o_grant = o_grant_valid ? (GRANT_WIDTH'(1) << grantee) : '0;
    end else begin : g_index
      assign o_grant = o_grant_valid ? GRANT_WIDTH'(grantee) : '0;
    end
  endgenerate
endmodule

// File: tb/tb_pzbcm_wrr_arbiter.sv
// tb/tb_pzbcm_wrr_arbiter.sv - scoreboard bench for pzbcm_wrr_arbiter (4 requesters, one-hot grant)
module tb_pzbcm_wrr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] weight = 32'h01010101;
  logic [3:0]  request = 4'h0;
  logic        free = 1'b0;
  logic        grant_valid;
  logic [3:0]  grant;

  typedef struct {
    logic        v;
    logic [3:0]  g;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  pzbcm_wrr_arbiter #(
    .REQUESTS     (4),
    .WEIGHT_WIDTH (8),
    .ONEHOT_GRANT (1)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_clear       (clear),
    .i_weight      (weight),
    .i_request     (request),
    .i_free        (free),
    .o_grant_valid (grant_valid),
    .o_grant       (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic ev, input logic [3:0] eg);
    checks++;
    if (grant_valid !== ev || grant !== eg) begin
      errors++;
      $display("FAIL %s: got valid=%0b grant=%b, expected valid=%0b grant=%b",
               name, grant_valid, grant, ev, eg);
    end
  endtask

  // Monitor: each falling edge, compare outputs against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, e.v, e.g);
      end
    end
  end

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input string name, input logic [3:0] req, input logic fr, input logic clr,
                      input logic ev, input int gi);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n   = 1'b1;
    request = req;
    free    = fr;
    clear   = clr;
    e.v     = ev;
    e.g     = ev ? oh(gi) : 4'h0;
    e.name  = name;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    #1;
    e.v = 1'b0; e.g = 4'h0; e.name = "reset_state";
    q.push_back(e);

    // Equal weights: plain round robin, no bubbles
    step("rr_first", 4'hF, 1'b0, 1'b0, 1'b1, 0);
    step("rr_1",     4'hF, 1'b1, 1'b0, 1'b1, 1);
    step("rr_2",     4'hF, 1'b1, 1'b0, 1'b1, 2);
    step("rr_3",     4'hF, 1'b1, 1'b0, 1'b1, 3);
    step("rr_wrap0", 4'hF, 1'b1, 1'b0, 1'b1, 0);
    step("rr_wrap1", 4'hF, 1'b1, 1'b0, 1'b1, 1);
    step("rr_idle",  4'h0, 1'b1, 1'b0, 1'b0, 0);

    // Weights {3,1}: 0,0,0,1 repeating
    weight = 32'h01010103;
    step("w31_0a", 4'b0011, 1'b1, 1'b0, 1'b1, 0);
    step("w31_0b", 4'b0011, 1'b1, 1'b0, 1'b1, 0);
    step("w31_0c", 4'b0011, 1'b1, 1'b0, 1'b1, 0);
    step("w31_1",  4'b0011, 1'b1, 1'b0, 1'b1, 1);
    step("w31_0d", 4'b0011, 1'b1, 1'b0, 1'b1, 0);
    step("w31_0e", 4'b0011, 1'b1, 1'b0, 1'b1, 0);
    step("w31_0f", 4'b0011, 1'b1, 1'b0, 1'b1, 0);
    step("w31_1b", 4'b0011, 1'b1, 1'b0, 1'b1, 1);
    step("w31_idle", 4'b0000, 1'b1, 1'b0, 1'b0, 0);

    // Weight 4 on req2; withdrawal after two frees discards remaining credit
    weight = 32'h01040101;
    step("wd_grant2",  4'b1100, 1'b0, 1'b0, 1'b1, 2);
    step("wd_free1",   4'b1100, 1'b1, 1'b0, 1'b1, 2);
    step("wd_free2",   4'b1100, 1'b1, 1'b0, 1'b1, 2);
    step("wd_move3",   4'b1000, 1'b0, 1'b0, 1'b1, 3);
    step("wd_idle",    4'b0000, 1'b1, 1'b0, 1'b0, 0);

    // Withdrawal without free, then clear coincident with free
    weight = 32'h01010101;
    step("cl_grant1",  4'b0010, 1'b0, 1'b0, 1'b1, 1);
    step("cl_move3",   4'b1000, 1'b0, 1'b0, 1'b1, 3);
    step("cl_clear",   4'hF,    1'b1, 1'b1, 1'b0, 0);
    step("cl_after",   4'hF,    1'b0, 1'b0, 1'b1, 0);
    step("cl_idle",    4'h0,    1'b1, 1'b0, 1'b0, 0);

    // Asynchronous reset mid-burst (credit 2)
    weight = 32'h01010103;
    step("rs_grant0",  4'b0001, 1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    request = 4'hF;
    free    = 1'b0;
    #1;
    check("rs_async", 1'b0, 4'h0);
    e.v = 1'b0; e.g = 4'h0; e.name = "rs_held";
    q.push_back(e);
    step("rs_first0",  4'hF, 1'b0, 1'b0, 1'b1, 0);
    step("rs_burst_a", 4'hF, 1'b1, 1'b0, 1'b1, 0);
    step("rs_burst_b", 4'hF, 1'b1, 1'b0, 1'b1, 0);
    step("rs_next1",   4'hF, 1'b1, 1'b0, 1'b1, 1);
    step("rs_idle",    4'h0, 1'b1, 1'b0, 1'b0, 0);

    // Weight 0 on req1
    weight = 32'h01010001;
`ifdef PZBCM_WRR_ARBITER_WEIGHT_ZERO_SKIP_EN
    for (int i = 0; i < 10; i++) step("wz_skip", 4'b0010, 1'b0, 1'b0, 1'b0, 0);
`else
    step("wz_grant1", 4'b0010, 1'b0, 1'b0, 1'b1, 1);
    step("wz_to0",    4'b0011, 1'b1, 1'b0, 1'b1, 0);
    step("wz_back1",  4'b0011, 1'b1, 1'b0, 1'b1, 1);
    step("wz_to0b",   4'b0011, 1'b1, 1'b0, 1'b1, 0);
`endif
    step("wz_idle",   4'b0000, 1'b1, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pzbcm_wrr_arbiter.md
# pzbcm_wrr_arbiter

Weighted round-robin arbiter with registered, held grants and a free handshake.
- Each requester gets up to `weight` consecutive transactions (grant-to-free pairs) before the round-robin pointer advances.
- It is the weighted successor to the fixed-priority and round-robin arbiters in the pzbcm arbiter family.
- It sits in front of shared buses, memory ports and crossbar outputs, where bandwidth must be split by ratio rather than equally.

## Interface
Parameters:
- REQUESTS, 4, number of requesters; legal range 1 to PZBCM_ARBITER_MAX_REQUESTS (32).
- WEIGHT_WIDTH, PZBCM_ARBITER_WEIGHT_WIDTH (8), bit width of each weight.
- ONEHOT_GRANT, 1, selects the grant encoding: 1 = one-hot, 0 = binary index. Grant width is calc_grant_width(REQUESTS, ONEHOT_GRANT).

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_clear, input, 1, synchronous clear: drops the grant and restores the reset pointer and credit.
- i_weight, input, REQUESTS×WEIGHT_WIDTH, per-requester weight; sampled only when a new grant is issued.
- i_request, input, REQUESTS, request vector.
- i_free, input, 1, current grantee has completed one transaction.
- o_grant_valid, output, 1, a grant is held.
- o_grant, output, calc_grant_width, grantee; one-hot or binary index; zero when o_grant_valid=0.

## Operation
- State:
  - grant register (valid + index);
  - pointer (index of the last new grantee), reset value REQUESTS-1;
  - credit counter, WEIGHT_WIDTH bits, reset value 0.
- States:
  - IDLE (o_grant_valid=0);
  - GRANTED (o_grant_valid=1).
- Arbitration event, in priority order:
  - (a) i_clear=1 → IDLE; pointer=REQUESTS-1; credit=0. This applies regardless of all other inputs.
  - (b) IDLE and |i_request → new grant.
  - (c) GRANTED, i_free=1, credit≠0 and i_request[grantee]=1 → burst continues. Same grantee is held; credit decrements by 1; pointer is unchanged.
  - (d) GRANTED, i_free=1, otherwise → new grant if |i_request, else IDLE with credit=0.
  - (e) GRANTED, i_free=0, i_request[grantee]=0 (request withdrawn) → treated as an implicit free with credit forced to 0. Proceeds as in (d).
  - (f) Anything else → hold. i_free while IDLE is ignored.
- New grant:
  - Search i_request cyclically, starting at pointer+1 and wrapping at REQUESTS-1 → 0.
  - The first set bit wins. The previous grantee is therefore naturally lowest priority.
  - Load pointer = winner and credit = max(i_weight[winner],1) - 1.
- Weight changes during a burst do not affect the burst in progress.
- Credit arithmetic is unsigned and never wraps below 0.
- REQUESTS=1: the pointer is constant. The block reduces to a burst counter, and o_grant is 1'b1 (one-hot) or 1'b0 (index).

## Timing
- All outputs are registered; there is no combinational path from an input to an output.
- Request arrives in IDLE at cycle N → o_grant_valid=1 at N+1.
- i_free at cycle M with a request pending → the next grantee appears at M+1. o_grant_valid stays 1 with no bubble.
- i_free at M with no requests → o_grant_valid=0 at M+1.
- Withdrawn request at cycle M → the grant moves or drops at M+1.
- i_clear at M → o_grant_valid=0 at M+1, even if i_free or i_request are also active at M.
- i_rst_n low at any time, including mid-burst:
  - outputs are 0 immediately (asynchronously);
  - pointer=REQUESTS-1 and credit=0;
  - the first grant after reset release goes to the lowest set request index.

## Configuration
- PZBCM_WRR_ARBITER_WEIGHT_ZERO_SKIP_EN:
  - Defined: a requester with i_weight=0 is masked out of the new-grant search and never receives a grant, even if it is the only requester. In that case the arbiter stays IDLE.
  - Undefined (default): weight 0 is treated as weight 1, giving one transaction per turn.

## Test plan
- REQUESTS=4, weights {1,1,1,1}, i_request=4'hF, i_free=1 every grant cycle → grant order 0,1,2,3,0,1 with o_grant_valid continuously 1.
- Weights {3,1,x,x}, i_request=4'b0011, i_free every cycle → order 0,0,0,1,0,0,0,1.
- Weight[2]=4, only req2 plus req3 active; req2 deasserts after its 2nd free → grant moves to 3 on the next cycle and req2's remaining credit is discarded.
- Grantee 1 drops its request with no i_free while req 3 is pending → o_grant=3 one cycle later; then i_clear coincident with i_free → o_grant_valid=0 next cycle, and the following arbitration with 4'hF grants 0.
- Assert i_rst_n=0 mid-burst (credit=2) → o_grant_valid/o_grant=0 without a clock edge; after release with 4'hF the first grant is 0 with credit reloaded.
- Weight[1]=0, i_request=4'b0010: with the macro → no grant for 10 cycles; without the macro → granted for exactly 1 free per turn.
